// File: rtl/stopwatch_pkg.sv
// Shared definitions for the stopwatch timekeeping datapath and the display
// driver that consumes its BCD output.
//
// Contents:
//   BCD_W          width of one BCD digit
//   DIGITS_W       width of the packed {sec_tens, sec_ones, cs_tens, cs_ones} bus
//   *_MAX          largest legal value of each digit position
//   *_LSB          bit offset of each digit inside the packed bus
package stopwatch_pkg;

    localparam int BCD_W    = 4;
    localparam int DIGITS_W = 4 * BCD_W;

    // Largest value each digit may hold before it rolls over to 0.
    localparam int CS_ONES_MAX  = 9;
    localparam int CS_TENS_MAX  = 9;
    localparam int SEC_ONES_MAX = 9;
    localparam int SEC_TENS_MAX = 5;

    // Field offsets inside the packed digits bus.
    localparam int CS_ONES_LSB  = 0;
    localparam int CS_TENS_LSB  = 4;
    localparam int SEC_ONES_LSB = 8;
    localparam int SEC_TENS_LSB = 12;

endpackage

// File: rtl/bcd_digit_cnt.sv
// One BCD digit of the stopwatch time value, chained to its neighbours
// through carry.
//
// Ports:
//   clk    in   rising-edge clock
//   reset  in   synchronous active-high reset, digit -> 0
//   clr    in   synchronous clear, digit -> 0 (lower priority than reset)
//   inc    in   advance the digit by one on this edge
//   digit  out  current digit value, registered
//   carry  out  combinational: inc & (digit == MAX); increments the next digit
module bcd_digit_cnt
    import stopwatch_pkg::*;
#(
    parameter int MAX = 9
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clr,
    input  logic             inc,
    output logic [BCD_W-1:0] digit,
    output logic             carry
);

    localparam logic [BCD_W-1:0] MAX_D = BCD_W'(MAX);

    always_ff @(posedge clk) begin
        if (reset || clr) begin
            digit <= '0;
        end else if (inc) begin
            // ">=" rather than "==": an out-of-range value (never reached in
            // normal operation) is folded back to 0 on the next increment.
            if (digit >= MAX_D) begin
                digit <= '0;
            end else begin
                digit <= digit + BCD_W'(1);
            end
        end
    end

    assign carry = inc && (digit == MAX_D);

endmodule

// File: rtl/stopwatch_counter.sv
// Timekeeping datapath of the stopwatch. Divides the board clock down to
// centisecond ticks and keeps a 4-digit BCD time value SS.CC (00.00-59.99).
//
// Ports:
//   clk            in   system clock, rising edge
//   reset          in   synchronous active-high reset
//   init_regs      in   synchronous clear of time and prescaler
//   count_enabled  in   advance time while high; hold (with phase) while low
//   digits         out  {sec_tens, sec_ones, cs_tens, cs_ones}, registered
//   tick           out  one-cycle pulse in the cycle the centisecond changes
//   wrap           out  one-cycle pulse in the cycle digits roll 59.99 -> 00.00
module stopwatch_counter
    import stopwatch_pkg::*;
#(
    parameter int TICKS_PER_CS = 1_000_000,
    parameter int PRESCALE_W   = 20
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                init_regs,
    input  logic                count_enabled,
    output logic [DIGITS_W-1:0] digits,
    output logic                tick,
    output logic                wrap
);

    localparam logic [PRESCALE_W-1:0] PRESCALE_LAST = PRESCALE_W'(TICKS_PER_CS - 1);

    logic [PRESCALE_W-1:0] prescale;
    logic                  cs_inc;

    logic [BCD_W-1:0] cs_ones;
    logic [BCD_W-1:0] cs_tens;
    logic [BCD_W-1:0] sec_ones;
    logic [BCD_W-1:0] sec_tens;

    logic cs_ones_carry;
    logic cs_tens_carry;
    logic sec_ones_carry;
    logic sec_tens_carry;

    // A centisecond elapses on the enabled edge that finds the prescaler at
    // its last count. Gating by count_enabled is what preserves the partial
    // interval across a pause.
    assign cs_inc = count_enabled && (prescale == PRESCALE_LAST);

    always_ff @(posedge clk) begin
        if (reset || init_regs) begin
            prescale <= '0;
        end else if (count_enabled) begin
            if (cs_inc) begin
                prescale <= '0;
            end else begin
                prescale <= prescale + PRESCALE_W'(1);
            end
        end
    end

    bcd_digit_cnt #(.MAX(CS_ONES_MAX)) u_cs_ones (
        .clk   (clk),
        .reset (reset),
        .clr   (init_regs),
        .inc   (cs_inc),
        .digit (cs_ones),
        .carry (cs_ones_carry)
    );

    bcd_digit_cnt #(.MAX(CS_TENS_MAX)) u_cs_tens (
        .clk   (clk),
        .reset (reset),
        .clr   (init_regs),
        .inc   (cs_ones_carry),
        .digit (cs_tens),
        .carry (cs_tens_carry)
    );

    bcd_digit_cnt #(.MAX(SEC_ONES_MAX)) u_sec_ones (
        .clk   (clk),
        .reset (reset),
        .clr   (init_regs),
        .inc   (cs_tens_carry),
        .digit (sec_ones),
        .carry (sec_ones_carry)
    );

    bcd_digit_cnt #(.MAX(SEC_TENS_MAX)) u_sec_tens (
        .clk   (clk),
        .reset (reset),
        .clr   (init_regs),
        .inc   (sec_ones_carry),
        .digit (sec_tens),
        .carry (sec_tens_carry)
    );

    assign digits[CS_ONES_LSB  +: BCD_W] = cs_ones;
    assign digits[CS_TENS_LSB  +: BCD_W] = cs_tens;
    assign digits[SEC_ONES_LSB +: BCD_W] = sec_ones;
    assign digits[SEC_TENS_LSB +: BCD_W] = sec_tens;

    // Flags are registered on the same edge that updates the digits, so they
    // line up with the new value. The top of the carry chain is the full wrap.
    always_ff @(posedge clk) begin
        if (reset || init_regs) begin
            tick <= 1'b0;
            wrap <= 1'b0;
        end else begin
            tick <= cs_inc;
            wrap <= sec_tens_carry;
        end
    end

endmodule

// File: tb/tb_stopwatch_counter.sv
module tb_stopwatch_counter;

    localparam int TPC     = 4;
    localparam int FULL_CS = 6000;

    // ---------------- clock / reset ----------------
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        init_regs = 1'b0;
    logic        count_enabled = 1'b1;
    logic [15:0] digits;
    logic        tick;
    logic        wrap;

    always #5 clk = ~clk;

    stopwatch_counter #(
        .TICKS_PER_CS (TPC),
        .PRESCALE_W   (3)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .init_regs     (init_regs),
        .count_enabled (count_enabled),
        .digits        (digits),
        .tick          (tick),
        .wrap          (wrap)
    );

    int vectors    = 0;
    int miscompares = 0;
    int tick_cnt   = 0;
    int wrap_cnt   = 0;
    int cycle      = 0;

    // ---------------- behavioural model ----------------
    // The whole state is "number of enabled edges since the last clear";
    // digits, tick and wrap all follow from it arithmetically.
    int en_edges = 0;
    logic [17:0] exp_q[$];

    function automatic logic [15:0] bcd_of(input int n);
        int cs;
        cs = (n / TPC) % FULL_CS;
        return {4'(cs / 1000), 4'((cs / 100) % 10), 4'((cs / 10) % 10), 4'(cs % 10)};
    endfunction

    always @(posedge clk) begin
        automatic int nxt;
        automatic logic tk;
        automatic logic wr;
        if (reset || init_regs) begin
            nxt = 0;
            tk  = 1'b0;
            wr  = 1'b0;
        end else if (count_enabled) begin
            nxt = en_edges + 1;
            tk  = (nxt % TPC) == 0;
            wr  = (nxt % (TPC * FULL_CS)) == 0;
        end else begin
            nxt = en_edges;
            tk  = 1'b0;
            wr  = 1'b0;
        end
        en_edges <= nxt;
        exp_q.push_back({bcd_of(nxt), tk, wr});
    end

    // ---------------- scoreboard: per-cycle compare ----------------
    always @(negedge clk) begin
        logic [17:0] e;
        cycle++;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            vectors++;
            if ({digits, tick, wrap} !== e) begin
                miscompares++;
                $display("FAIL cycle_check @%0d: got digits=%h tick=%b wrap=%b, expected digits=%h tick=%b wrap=%b",
                         cycle, digits, tick, wrap, e[17:2], e[1], e[0]);
            end
        end
    end

    // pulse counters sampled shortly after the active edge
    always @(posedge clk) begin
        #1;
        if (tick === 1'b1) tick_cnt++;
        if (wrap === 1'b1) wrap_cnt++;
    end

    // ---------------- driver tasks ----------------
    task automatic drive(input logic rst, input logic init, input logic en, input int n);
        repeat (n) begin
            @(negedge clk);
            reset         = rst;
            init_regs     = init;
            count_enabled = en;
        end
    endtask

    // One idle (disabled) edge; on return the outputs reflect the last driven edge.
    task automatic settle();
        drive(1'b0, 1'b0, 1'b0, 1);
    endtask

    task automatic clear();
        drive(1'b0, 1'b1, 1'b0, 1);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    // ---------------- test sequence ----------------
    initial begin
        // reset held 2 cycles with count_enabled high
        drive(1'b1, 1'b0, 1'b1, 2);
        settle();
        check("reset_digits", 32'(digits), 32'h0000);
        check("reset_tick", 32'(tick), 32'h0);
        check("reset_wrap", 32'(wrap), 32'h0);

        // basic count: 40 enabled cycles -> 00.10, 10 ticks
        tick_cnt = 0;
        drive(1'b0, 1'b0, 1'b1, 40);
        settle();
        check("basic_digits", 32'(digits), 32'h0010);
        check("basic_ticks", 32'(tick_cnt), 32'd10);

        // pause preserves phase: 2 on, 5 off, 2 on -> one tick
        clear();
        tick_cnt = 0;
        drive(1'b0, 1'b0, 1'b1, 2);
        drive(1'b0, 1'b0, 1'b0, 5);
        drive(1'b0, 1'b0, 1'b1, 2);
        settle();
        check("pause_digits", 32'(digits), 32'h0001);
        check("pause_ticks", 32'(tick_cnt), 32'd1);

        // carry chain
        clear();
        drive(1'b0, 1'b0, 1'b1, TPC * 100);
        settle();
        check("carry_0100", 32'(digits), 32'h0100);
        drive(1'b0, 1'b0, 1'b1, TPC * 899);
        settle();
        check("carry_0999", 32'(digits), 32'h0999);
        drive(1'b0, 1'b0, 1'b1, TPC);
        settle();
        check("carry_1000", 32'(digits), 32'h1000);

        // full wrap
        clear();
        drive(1'b0, 1'b0, 1'b1, TPC * 5999);
        settle();
        check("wrap_5999", 32'(digits), 32'h5999);
        wrap_cnt = 0;
        drive(1'b0, 1'b0, 1'b1, TPC);
        settle();
        check("wrap_digits", 32'(digits), 32'h0000);
        check("wrap_tick", 32'(tick), 32'h1);
        check("wrap_flag", 32'(wrap), 32'h1);
        check("wrap_count", 32'(wrap_cnt), 32'd1);

        // init_regs wins over count_enabled mid-interval
        clear();
        drive(1'b0, 1'b0, 1'b1, TPC * 23 + 2);
        settle();
        check("init_pre_digits", 32'(digits), 32'h0023);
        drive(1'b0, 1'b1, 1'b1, 1);
        settle();
        check("init_digits", 32'(digits), 32'h0000);
        tick_cnt = 0;
        drive(1'b0, 1'b0, 1'b1, TPC - 1);
        settle();
        check("init_no_early_tick", 32'(tick_cnt), 32'd0);
        drive(1'b0, 1'b0, 1'b1, 1);
        settle();
        check("init_tick", 32'(tick_cnt), 32'd1);
        check("init_post_digits", 32'(digits), 32'h0001);

        // randomized traffic, checked cycle by cycle by the scoreboard
        for (int i = 0; i < 3000; i++) begin
            drive(($urandom_range(0, 199) == 0), ($urandom_range(0, 99) == 0),
                  ($urandom_range(0, 3) != 0), 1);
        end
        settle();
        repeat (3) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
